// File: rtl/regbank_port_arbiter.sv
// Round-robin arbiter sharing the register bank's single write and read ports among requesters.
// Define REGBANK_ARB_RO_PROTECT_EN to block writes to RO_ADDR and flag them on err.
module regbank_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RO_ADDR    = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             err,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rvalid,
  output logic [$clog2(NUM_REQ)-1:0]       rid,
  output logic                             rb_w_en,
  output logic [ADDR_WIDTH-1:0]            rb_w_addr,
  output logic [DATA_WIDTH-1:0]            rb_w_data,
  output logic [ADDR_WIDTH-1:0]            rb_r_addr,
  input  logic [DATA_WIDTH-1:0]            rb_busB
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [IdW-1:0]        last_winner;
  logic [IdW-1:0]        win_idx;
  logic [IdW-1:0]        cand;
  logic [IdW-1:0]        rd_id;
  logic                  rd_pend;
  logic                  found;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  ro_hit;
  logic                  ro_block;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A requester granted this cycle is masked so a held req is not granted twice.
  assign eligible = req & ~gnt;

  always_comb begin
    found   = 1'b0;
    win_idx = last_winner;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdW'((32'(last_winner) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_we   = req_we[win_idx];
  assign win_addr = addr_arr[win_idx];
  assign win_data = data_arr[win_idx];
  assign ro_hit   = win_we && (win_addr == ADDR_WIDTH'(RO_ADDR));

`ifdef REGBANK_ARB_RO_PROTECT_EN
  assign ro_block = ro_hit;
`else
  assign ro_block = ro_hit & 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt         <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      rvalid      <= 1'b0;
      rid         <= '0;
      rb_w_en     <= 1'b0;
      rb_w_addr   <= '0;
      rb_w_data   <= '0;
      rb_r_addr   <= '0;
      rd_pend     <= 1'b0;
      rd_id       <= '0;
      last_winner <= IdW'(NUM_REQ - 1);
    end else begin
      gnt     <= '0;
      err     <= 1'b0;
      rb_w_en <= 1'b0;
      rvalid  <= rd_pend;
      rd_pend <= 1'b0;
      if (rd_pend) begin
        rdata <= rb_busB;
        rid   <= rd_id;
      end
      if (found) begin
        gnt         <= NUM_REQ'(1) << win_idx;
        last_winner <= win_idx;
        if (win_we) begin
          rb_w_en   <= !ro_block;
          rb_w_addr <= win_addr;
          rb_w_data <= win_data;
          err       <= ro_block;
        end else begin
          rb_r_addr <= win_addr;
          rd_pend   <= 1'b1;
          rd_id     <= win_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_regbank_port_arbiter.sv
// Self-checking bench for regbank_port_arbiter: a small register bank, a behavioural
// reference model compared every cycle, and directed vectors with literal expectations.
module tb_regbank_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 4;
`ifdef REGBANK_ARB_RO_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   gnt;
  logic            err, rvalid, rb_w_en;
  logic [DW-1:0]   rdata, rb_w_data, rb_busB;
  logic [1:0]      rid;
  logic [AW-1:0]   rb_w_addr, rb_r_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regbank_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .err       (err),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rid       (rid),
    .rb_w_en   (rb_w_en),
    .rb_w_addr (rb_w_addr),
    .rb_w_data (rb_w_data),
    .rb_r_addr (rb_r_addr),
    .rb_busB   (rb_busB)
  );

  // Register bank: entry i resets to i, entry 6 holds the -1 constant.
  logic [DW-1:0] bank [8];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= (i == 6) ? 8'hFF : 8'(i);
    end else if (rb_w_en) begin
      bank[rb_w_addr] <= rb_w_data;
    end
  end
  assign rb_busB = bank[rb_r_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs derived from the arbitration rules.
  int           m_last;
  logic [NR-1:0] m_gnt;
  bit           m_err, m_wen, m_rvalid, m_pend;
  logic [AW-1:0] m_waddr, m_raddr;
  logic [DW-1:0] m_wdata, m_rdata, m_pdata;
  int           m_rid, m_pid;
  logic [DW-1:0] m_mem [8];

  always @(posedge clk or posedge rst) begin : model
    int w;
    int a;
    if (rst) begin
      m_last = NR - 1;
      m_gnt = '0; m_err = 0; m_wen = 0; m_rvalid = 0; m_pend = 0;
      m_waddr = '0; m_raddr = '0; m_wdata = '0; m_rdata = '0; m_pdata = '0;
      m_rid = 0; m_pid = 0;
      for (int i = 0; i < 8; i++) m_mem[i] = (i == 6) ? 8'hFF : 8'(i);
    end else begin
      m_rvalid = m_pend;
      if (m_pend) begin
        m_rdata = m_pdata;
        m_rid   = m_pid;
      end
      m_pend = 0;
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_last + k) % NR;
        if (w < 0 && req[i] && !m_gnt[i]) w = i;
      end
      m_gnt = '0; m_wen = 0; m_err = 0;
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_last   = w;
        a = int'(req_addr[w*AW +: AW]);
        if (req_we[w]) begin
          m_waddr = 3'(a);
          m_wdata = req_wdata[w*DW +: DW];
          if (PROT && a == 6) m_err = 1;
          else begin
            m_wen = 1;
            m_mem[a] = m_wdata;
          end
        end else begin
          m_raddr = 3'(a);
          m_pend  = 1;
          m_pid   = w;
          m_pdata = m_mem[a];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("err", 32'(err), 32'(m_err));
    chk("rb_w_en", 32'(rb_w_en), 32'(m_wen));
    chk("rb_r_addr", 32'(rb_r_addr), 32'(m_raddr));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    if (rst || m_wen) begin
      chk("rb_w_addr", 32'(rb_w_addr), 32'(m_waddr));
      chk("rb_w_data", 32'(rb_w_data), 32'(m_wdata));
    end
    if (rst || m_rvalid) begin
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("rid", 32'(rid), 32'(m_rid));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input bit we, input int a, input int d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = 3'(a);
    req_wdata[i*DW +: DW] = 8'(d);
  endtask

  task automatic drop(input int i);
    req[i] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rvalid"}, 32'(rvalid), 0);
    chk({tag, "_wen"}, 32'(rb_w_en), 0);
    chk({tag, "_waddr"}, 32'(rb_w_addr), 0);
    chk({tag, "_wdata"}, 32'(rb_w_data), 0);
    chk({tag, "_raddr"}, 32'(rb_r_addr), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_rid"}, 32'(rid), 0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cyc();
    cyc();
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Write 0x5A to addr 7.
    drive(0, 1, 7, 'h5A);
    cyc();
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_wen", 32'(rb_w_en), 1);
    chk("wr_waddr", 32'(rb_w_addr), 7);
    chk("wr_wdata", 32'(rb_w_data), 32'h5A);
    drop(0);
    cyc();
    chk("wr_wen_off", 32'(rb_w_en), 0);
    chk("wr_gnt_off", 32'(gnt), 0);

    // Read addr 3 from requester 2.
    drive(2, 0, 3, 0);
    cyc();
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_raddr", 32'(rb_r_addr), 3);
    drop(2);
    cyc();
    chk("rd_rvalid", 32'(rvalid), 1);
    chk("rd_rdata", 32'(rdata), 3);
    chk("rd_rid", 32'(rid), 2);

    // Write to the constant register, then read it back (held req is masked one cycle).
    drive(1, 1, 6, 0);
    cyc();
    chk("ro_gnt", 32'(gnt), 32'h2);
    chk("ro_err", 32'(err), 32'(PROT));
    chk("ro_wen", 32'(rb_w_en), 32'(!PROT));
    drive(1, 0, 6, 0);
    cyc();
    chk("mask_gnt", 32'(gnt), 0);
    cyc();
    chk("ro_rd_gnt", 32'(gnt), 32'h2);
    drop(1);
    cyc();
    chk("ro_rvalid", 32'(rvalid), 1);
    chk("ro_rdata", 32'(rdata), PROT ? 32'hFF : 32'h00);

    // Write then immediately read the same address.
    drive(0, 1, 5, 'hC3);
    cyc();
    chk("fw_wgnt", 32'(gnt), 32'h1);
    drop(0);
    drive(1, 0, 5, 0);
    cyc();
    chk("fw_rgnt", 32'(gnt), 32'h2);
    chk("fw_raddr", 32'(rb_r_addr), 5);
    drop(1);
    cyc();
    chk("fw_rvalid", 32'(rvalid), 1);
    chk("fw_rdata", 32'(rdata), 32'hC3);
    chk("fw_rid", 32'(rid), 1);

    // All four reading continuously: strict rotation 0,1,2,3,0.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) drive(i, 0, i, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_gnt", 32'(gnt), 32'(1) << (k % NR));
      if (k > 0) begin
        chk("rr_rvalid", 32'(rvalid), 1);
        chk("rr_rid", 32'(rid), 32'(k - 1));
        chk("rr_rdata", 32'(rdata), 32'(k - 1));
      end
    end
    req = '0;
    cyc();
    chk("rr_last_rvalid", 32'(rvalid), 1);
    chk("rr_last_rid", 32'(rid), 0);

    // Reset right after a read grant drops the pending read.
    drive(2, 0, 2, 0);
    cyc();
    chk("mid_gnt", 32'(gnt), 32'h4);
    drop(2);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid");
    cyc();
    chk("mid_rvalid", 32'(rvalid), 0);
    rst = 1'b0;
    drive(2, 0, 1, 0);
    drive(3, 1, 4, 'h77);
    cyc();
    chk("post_gnt", 32'(gnt), 32'h4);
    drop(2);
    cyc();
    chk("post_gnt2", 32'(gnt), 32'h8);
    chk("post_wen", 32'(rb_w_en), 1);
    chk("post_rvalid", 32'(rvalid), 1);
    chk("post_rdata", 32'(rdata), 1);
    chk("post_rid", 32'(rid), 2);
    drop(3);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_port_arbiter.md
# regbank_port_arbiter

Round-robin arbiter and sequencer that shares the single write port and single read port of the 8-entry CPU register bank among several requesters, such as fetch, execute, stack and debug units. It sits directly in front of the register bank. Each cycle it grants one read or write transaction and drives the bank's write and read controls from registers. Read data returns with a fixed latency, and the block optionally blocks writes to the constant register.

## Interface
Parameters:
- DATA_WIDTH, 8, register data width
- ADDR_WIDTH, 3, register address width
- NUM_REQ, 4, number of requesters (≥2)
- RO_ADDR, 6, read-only register address (the −1 constant)

Ports (clock and reset first):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-requester request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- gnt  out  NUM_REQ  one-hot, single-cycle grant pulse
- err  out  1  pulses with gnt when a write to RO_ADDR is blocked
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  rdata valid, single-cycle pulse
- rid  out  $clog2(NUM_REQ)  index of the requester that owns rdata
- rb_w_en  out  1  bank write enable
- rb_w_addr  out  ADDR_WIDTH  bank write address
- rb_w_data  out  DATA_WIDTH  bank write data
- rb_r_addr  out  ADDR_WIDTH  bank read address
- rb_busB  in  DATA_WIDTH  bank read data (combinational from rb_r_addr)

## Operation
- Eligible set in each cycle: {i | req[i]=1 and gnt[i]=0}. A requester that is being granted in the current cycle is masked, so a held req is not granted twice for one transaction.
- Winner: the first eligible index found by searching upward from (last_winner+1) mod NUM_REQ. After a grant, last_winner takes the winner's index.
- At the clock edge the winner is registered:
  - gnt[winner]=1.
  - Write grant: rb_w_en=1, rb_w_addr and rb_w_data come from the winner.
  - Read grant: rb_w_en=0, rb_r_addr comes from the winner, and an internal read-pending flag is set together with the winner's index.
- If the read-pending flag is set, the next edge captures rb_busB into rdata, asserts rvalid=1 and loads rid.
- rb_r_addr holds its last value when there is no read grant. rb_w_addr and rb_w_data may hold their values, but rb_w_en=0 whenever there is no write grant.
- Requester handshake: hold req, we, addr and wdata stable until a cycle in which gnt[i]=1 is observed. After that, drop req or present the next transaction.
- If no requester is eligible, gnt=0, rb_w_en=0, and last_winner is unchanged.
- Reset: gnt=0, err=0, rb_w_en=0, rb_w_addr=0, rb_w_data=0, rb_r_addr=0, rdata=0, rvalid=0, rid=0, read-pending flag cleared, last_winner=NUM_REQ−1 (so requester 0 has priority first).
- Reset asserted mid-transaction: any pending read is dropped and rvalid is not asserted for it. A write whose edge coincides with rst is not performed.

## Timing
- Request sampled in cycle N → gnt and the bank controls are active in cycle N+1. The bank write lands at the end of cycle N+1.
- Read granted in N+1 → rvalid, rdata and rid are valid in N+2.
- Throughput is one transaction per cycle. A read and a write are never granted in the same cycle.
- Write to address X granted in cycle K, then a read of X granted in cycle K+1 or later → the read returns the new value, because the bank has already been written.
- With all NUM_REQ requesters continuously requesting, grants rotate strictly 0,1,…,NUM_REQ−1,0. No requester waits more than NUM_REQ−1 cycles.

## Configuration
- REGBANK_ARB_RO_PROTECT_EN defined:
  - A granted write with address equal to RO_ADDR still pulses gnt, but forces rb_w_en=0 and pulses err=1 in the same cycle.
- Not defined:
  - The write is passed to the bank unchanged and err is tied to 0.

## Test plan
- Reset, then req[0] writes addr 7 with 0x5A → in cycle N+1, gnt=0001, rb_w_en=1, rb_w_addr=7, rb_w_data=0x5A; in N+2, rb_w_en=0. All outputs are 0 during reset.
- req[3:0]=1111 held continuously, all reads → gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and each rvalid arrives 1 cycle after its gnt with the matching rid.
- After reset, req[2] reads addr 3 → rb_r_addr=3 in N+1; in N+2, rvalid=1, rdata=0x03, rid=2.
- With the macro defined, req[1] writes addr 6 with 0x00 → gnt=0010, err=1, rb_w_en=0; a subsequent read of addr 6 returns 0xFF. Without the macro → rb_w_en=1 and err=0.
- req[0] writes addr 5 with 0xC3, then req[1] reads addr 5 in the next cycle → rvalid with rdata=0xC3 and rid=1.
- rst asserted in the cycle after a read grant → rvalid stays 0, all outputs return to reset values, and the first grant after reset goes to the lowest-index requester.
